// File: rtl/dsp_sequencer.sv
// dsp_sequencer: microcoded control sequencer for the DSP datapath.
// Issues one control word per clock from a writable program memory.
// Supports one hardware loop (MARK/LOOP) that runs once per series element.
// A start/busy/done handshake frames each program run.
module dsp_sequencer #(
    parameter int PC_WIDTH     = 6,
    parameter int N_AGEN       = 3,
    parameter int OFFSET_WIDTH = 4,
    parameter int DSP_OP_WIDTH = 8,
    parameter int N_SERIES     = 25,
    parameter int LOOP_WIDTH   = 5
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 overrun,
    input  logic                                                 prog_we,
    input  logic [PC_WIDTH-1:0]                                  prog_addr,
    input  logic [N_AGEN*(4+OFFSET_WIDTH)+DSP_OP_WIDTH+2:0]      prog_data,
    output logic [N_AGEN*4-1:0]                                  addr_sel,
    output logic [N_AGEN*OFFSET_WIDTH-1:0]                       addr_ptr,
    output logic                                                 series_inc,
    output logic                                                 series_rst,
    output logic [DSP_OP_WIDTH-1:0]                              dsp_op,
    output logic [LOOP_WIDTH-1:0]                                loop_idx
);

    localparam int INSTR_WIDTH = N_AGEN*(4+OFFSET_WIDTH) + DSP_OP_WIDTH + 3;
    localparam int DEPTH       = 1 << PC_WIDTH;
    localparam int AGEN_W      = 4 + OFFSET_WIDTH;
    localparam int AGEN_LSB    = 3 + DSP_OP_WIDTH;
    localparam logic [LOOP_WIDTH-1:0] LOOP_LAST = LOOP_WIDTH'(N_SERIES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [PC_WIDTH-1:0]      pc, pc_nxt, rd_addr, mark_pc;
    logic [LOOP_WIDTH-1:0]    loop_cnt;
    logic                     overrun_q;
    logic                     first_q;      // first RUN cycle of a run
    logic                     take_loop;    // LOOP taken back to mark
    logic                     end_loop;     // LOOP falls through on last iteration
    logic                     ovf;          // ran past last word without HALT
    logic [INSTR_WIDTH-1:0]   mem [DEPTH];
    logic [INSTR_WIDTH-1:0]   rdata;

    wire w_mark = rdata[0];
    wire w_loop = rdata[1];
    wire w_halt = rdata[2];

    assign busy     = (state == S_FETCH) || (state == S_RUN);
    assign done     = (state == S_DONE);
    assign overrun  = overrun_q;
    assign loop_idx = loop_cnt;

    // Program memory: synchronous read every cycle, writes locked out while busy.
    always_ff @(posedge clk) begin
        if (prog_we && !busy)
            mem[prog_addr] <= prog_data;
        rdata <= mem[rd_addr];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state and next read address, decided from the word being issued.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc + 1'b1;
        rd_addr   = pc;
        take_loop = 1'b0;
        end_loop  = 1'b0;
        ovf       = 1'b0;
        case (state)
            S_IDLE: begin
                rd_addr = '0;
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: state_nxt = S_RUN;
            S_RUN: begin
                if (w_halt) begin
                    state_nxt = S_DONE;
                end else begin
                    if (w_loop && (loop_cnt < LOOP_LAST)) begin
                        take_loop = 1'b1;
                        // MARK on the same word makes a one-word loop
                        pc_nxt    = w_mark ? pc : mark_pc;
                    end else if (w_loop) begin
                        end_loop  = 1'b1;
                    end
                    if (!take_loop && (pc == '1)) begin
                        ovf       = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
                rd_addr = pc_nxt;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sequencer datapath: pc, mark, loop counter and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            mark_pc   <= '0;
            loop_cnt  <= '0;
            overrun_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    pc        <= '0;
                    mark_pc   <= '0;
                    loop_cnt  <= '0;
                    overrun_q <= 1'b0;
                end
                S_FETCH: first_q <= 1'b1;
                S_RUN: begin
                    first_q <= 1'b0;
                    pc      <= pc_nxt;
                    if (!w_halt && w_mark) mark_pc  <= pc;
                    if (take_loop)         loop_cnt <= loop_cnt + 1'b1;
                    if (end_loop)          loop_cnt <= '0;
                    if (ovf)               overrun_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Control outputs: issued word fields in RUN, zero otherwise.
    always_comb begin
        addr_sel   = '0;
        addr_ptr   = '0;
        dsp_op     = '0;
        series_inc = 1'b0;
        series_rst = 1'b0;
        if (state == S_RUN) begin
            dsp_op     = rdata[3 +: DSP_OP_WIDTH];
            series_inc = take_loop;
            series_rst = first_q || end_loop;
            for (int k = 0; k < N_AGEN; k++) begin
                addr_sel[4*k +: 4] = rdata[AGEN_LSB + k*AGEN_W +: 4];
                addr_ptr[OFFSET_WIDTH*k +: OFFSET_WIDTH] =
                    rdata[AGEN_LSB + k*AGEN_W + 4 +: OFFSET_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_dsp_sequencer.sv
// tb_dsp_sequencer: table of program runs checked word by word through a
// scoreboard queue, plus hand sequences for reset, mid-run start/write and
// mid-run reset.
module tb_dsp_sequencer;

    localparam int PW = 6, NA = 3, OW = 4, DW = 8, NS = 25, LW = 5;
    localparam int IW = NA*(4+OW) + DW + 3;

    logic            clk = 1'b0;
    logic            rst, start, prog_we;
    logic [PW-1:0]   prog_addr;
    logic [IW-1:0]   prog_data;
    logic            busy, done, overrun, series_inc, series_rst;
    logic [NA*4-1:0] addr_sel;
    logic [NA*OW-1:0] addr_ptr;
    logic [DW-1:0]   dsp_op;
    logic [LW-1:0]   loop_idx;

    dsp_sequencer #(.PC_WIDTH(PW), .N_AGEN(NA), .OFFSET_WIDTH(OW), .DSP_OP_WIDTH(DW),
                    .N_SERIES(NS), .LOOP_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .overrun(overrun),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .addr_sel(addr_sel), .addr_ptr(addr_ptr), .series_inc(series_inc),
        .series_rst(series_rst), .dsp_op(dsp_op), .loop_idx(loop_idx));

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] sel;
        logic [11:0] ptr;
        logic [7:0]  op;
        logic        inc;
        logic        srst;
        logic [4:0]  idx;
    } exp_t;

    typedef struct {
        int mark_at;
        int loop_at;
        int halt_at;
        int exp_busy;
        int exp_incs;
        bit exp_ovr;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vecs[6];
    logic [2:0]  img_ctl[64];
    logic [11:0] img_sel[64];
    logic [11:0] img_ptr[64];
    logic [7:0]  img_op[64];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [IW-1:0] enc(input logic [2:0] ctl, input logic [7:0] op,
                                          input logic [11:0] sel, input logic [11:0] ptr);
        return {ptr[11:8], sel[11:8], ptr[7:4], sel[7:4], ptr[3:0], sel[3:0], op, ctl};
    endfunction

    // Write a full 64-word program with the given MARK/LOOP/HALT positions (-1 = none).
    task automatic load_prog(input int mk, input int lp, input int ht);
        for (int a = 0; a < 64; a++) begin
            img_ctl[a] = {a == ht, a == lp, a == mk};
            img_sel[a] = 12'(a*37 + 1);
            img_ptr[a] = 12'(a*91 + 5);
            img_op[a]  = (a == ht) ? 8'h5A : 8'(a + 8'h30);
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = PW'(a);
            prog_data = enc(img_ctl[a], img_op[a], img_sel[a], img_ptr[a]);
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Interpret the shadow program and queue the expected issued words.
    task automatic build_expect();
        int pc = 0, mk = 0, cnt = 0, nxt, guard = 0;
        bit first = 1'b1, stop = 1'b0;
        exp_t e;
        sbq.delete();
        while (!stop && guard < 4000) begin
            guard++;
            e.sel = img_sel[pc]; e.ptr = img_ptr[pc]; e.op = img_op[pc];
            e.idx = 5'(cnt); e.inc = 1'b0; e.srst = first;
            first = 1'b0;
            if (img_ctl[pc][2]) begin
                stop = 1'b1;
            end else begin
                nxt = pc + 1;
                if (img_ctl[pc][1]) begin
                    if (cnt < NS-1) begin
                        e.inc = 1'b1; cnt++;
                        nxt = img_ctl[pc][0] ? pc : mk;
                    end else begin
                        e.srst = 1'b1; cnt = 0;
                    end
                end
                if (img_ctl[pc][0]) mk = pc;
                if (nxt == 64) stop = 1'b1;
                pc = nxt;
            end
            sbq.push_back(e);
        end
    endtask

    // One full run: start, compare every issued word, then done/overrun/counts.
    task automatic do_run(input int exp_busy, input int exp_incs, input bit exp_ovr);
        int nbusy, nincs;
        exp_t e;
        build_expect();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("fetch_busy_done", {busy, done}, 2'b10);
        check("overrun_cleared", overrun, 1'b0);
        nbusy = int'(busy); nincs = 0;
        while (sbq.size() > 0) begin
            @(negedge clk);
            e = sbq.pop_front();
            check("issued_word", {addr_sel, addr_ptr, dsp_op, series_inc, series_rst, loop_idx},
                  {e.sel, e.ptr, e.op, e.inc, e.srst, e.idx});
            nbusy += int'(busy);
            nincs += int'(series_inc);
        end
        @(negedge clk);
        check("done_pulse", {done, busy}, 2'b10);
        check("overrun_at_done", overrun, exp_ovr);
        check("busy_cycles", nbusy, exp_busy);
        check("series_inc_count", nincs, exp_incs);
        @(negedge clk);
        check("back_idle", {done, busy, series_rst, dsp_op}, '0);
        if (exp_ovr) begin
            repeat (3) @(negedge clk);
            check("overrun_holds_idle", overrun, 1'b1);
        end
    endtask

    initial begin
        int nb, tmo;
        vecs[0] = '{0,  1,  2,  52, 24, 1'b0};  // mark/loop/halt, 25 series
        vecs[1] = '{-1, -1, 3,  5,  0,  1'b0};  // straight line
        vecs[2] = '{5,  5,  5,  7,  0,  1'b0};  // HALT beats LOOP on same word
        vecs[3] = '{2,  2,  3,  29, 24, 1'b0};  // one-word loop
        vecs[4] = '{-1, -1, -1, 65, 0,  1'b1};  // no HALT: overrun
        vecs[5] = '{-1, 2,  3,  77, 24, 1'b0};  // LOOP before MARK jumps to 0

        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {busy, done, overrun, addr_sel, addr_ptr, series_inc,
                                series_rst, dsp_op, loop_idx}, '0);

        for (int v = 0; v < 6; v++) begin
            load_prog(vecs[v].mark_at, vecs[v].loop_at, vecs[v].halt_at);
            do_run(vecs[v].exp_busy, vecs[v].exp_incs, vecs[v].exp_ovr);
        end

        // start and prog_we pulsed mid-run are both ignored
        load_prog(0, 1, 2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nb = int'(busy);
        repeat (4) begin @(negedge clk); nb += int'(busy); end
        start = 1'b1; prog_we = 1'b1; prog_addr = '0;
        prog_data = enc(3'b000, 8'hFF, 12'hFFF, 12'hFFF);
        tmo = 0;
        @(negedge clk); nb += int'(busy);
        start = 1'b0; prog_we = 1'b0;
        while (!done && tmo < 300) begin @(negedge clk); nb += int'(busy); tmo++; end
        check("midrun_done_seen", done, 1'b1);
        check("midrun_busy_cycles", nb, 52);
        repeat (3) @(negedge clk);
        check("no_restart_after_done", busy, 1'b0);
        do_run(52, 24, 1'b0);   // word 0 must still be the original

        // reset in the 10th RUN cycle
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;   // cycle t+1 (FETCH)
        repeat (10) @(negedge clk);     // cycle t+11 = 10th RUN cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_midrun_outputs", {busy, done, overrun, addr_sel, addr_ptr, series_inc,
                                     series_rst, dsp_op, loop_idx}, '0);
        @(negedge clk);
        check("rst_midrun_no_done", {done, busy}, 2'b00);
        do_run(52, 24, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dsp_sequencer.md
# dsp_sequencer

Microcoded control sequencer sitting directly upstream of the `addr_gen` instances in the DSP datapath. It holds a writable program memory and issues one control word per clock. Each word carries the `addr_sel`, `addr_ptr`, `series_inc`/`series_rst` and DSP opcode fields. A single hardware loop repeats a program section once per series element (e.g. per harmonic), and a start/busy/done handshake frames each program run.

## Interface
- `PC_WIDTH`, 6: program counter width; program depth = 2**PC_WIDTH words.
- `N_AGEN`, 3: number of downstream `addr_gen` instances driven.
- `OFFSET_WIDTH`, 4: width of each `addr_ptr` field; must match `addr_gen` OFFSET_WIDTH.
- `DSP_OP_WIDTH`, 8: opcode field width, passed through to the DSP.
- `N_SERIES`, 25: loop iterations per run (≥1).
- `LOOP_WIDTH`, 5: loop counter width, must satisfy `2**LOOP_WIDTH ≥ N_SERIES`.
- Derived: `INSTR_WIDTH = N_AGEN*(4+OFFSET_WIDTH) + DSP_OP_WIDTH + 3`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request, sampled in IDLE only.
- `busy`  out  1  high from the cycle after an accepted start until the cycle of the DONE pulse, exclusive of DONE.
- `done`  out  1  one-cycle pulse at run end.
- `overrun`  out  1  sticky; set when PC runs past the last word without HALT; cleared by `rst` or an accepted `start`.
- `prog_we`  in  1  program write strobe; ignored while `busy`.
- `prog_addr`  in  PC_WIDTH  write address.
- `prog_data`  in  INSTR_WIDTH  write data.
- `addr_sel`  out  N_AGEN*4  per-agen `addr_sel`; agen k at bits [4k+3:4k].
- `addr_ptr`  out  N_AGEN*OFFSET_WIDTH  per-agen `addr_ptr`, same packing.
- `series_inc`  out  1  to all agens.
- `series_rst`  out  1  to all agens.
- `dsp_op`  out  DSP_OP_WIDTH  opcode for the issued word.
- `loop_idx`  out  LOOP_WIDTH  current loop iteration (debug).

## Operation
- Word layout, LSB first:
  - bit0 MARK, bit1 LOOP, bit2 HALT.
  - `dsp_op`.
  - Then for k = 0..N_AGEN-1: {addr_ptr_k, addr_sel_k}, with addr_sel_k in the lower bits.
- Program memory: synchronous read, one-cycle latency. Writes take one cycle. Contents are not cleared by `rst`.
- FSM states: IDLE, FETCH, RUN, DONE.
  - IDLE: on `start`, clear `overrun`, `loop_cnt` and `mark_pc`, read address 0, go to FETCH.
  - FETCH: one cycle, waiting for memory. Go to RUN.
  - RUN: the word at the memory output is issued this cycle. The next read address is computed combinationally from the issued word:
    - HALT: go to DONE. HALT takes priority over LOOP.
    - LOOP and `loop_cnt < N_SERIES-1`: assert `series_inc`, increment `loop_cnt`, next = `mark_pc`.
    - LOOP and `loop_cnt = N_SERIES-1`: assert `series_rst`, clear `loop_cnt`, next = pc+1.
    - Otherwise: next = pc+1.
    - MARK: `mark_pc` ← pc of the issued word. Applies even if LOOP is also set, giving a one-word loop.
    - pc = 2**PC_WIDTH-1 with no HALT and no branch taken: set `overrun`, go to DONE. No wrap.
  - DONE: `done`=1 for one cycle, go to IDLE.
- `series_rst` is also asserted on the first RUN cycle of every run.
- A LOOP word before any MARK jumps to 0. Nested loops are not supported.
- Control outputs (`addr_sel`, `addr_ptr`, `dsp_op`, `series_inc`, `series_rst`) are 0 in every state other than RUN.
- `start` while busy is ignored. `prog_we` while busy is ignored and memory is unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, `loop_cnt`=0, `mark_pc`=0.
- `rst` mid-run returns to IDLE on the next edge. No `done` pulse is generated.
- `start` at cycle t:
  - `busy`=1 from t+1.
  - Word 0 is issued at t+2.
  - Sustained rate is one word per cycle, including across taken loops (no bubble).
- HALT issued at cycle h: its fields still apply at h. `done`=1 and `busy`=0 at h+1. Earliest new `start` is accepted at h+2.
- The `series_inc`/`series_rst` register delay inside `addr_gen` is the program author's concern; the sequencer does not compensate for it.
- `loop_idx` equals `loop_cnt` and updates on the edge after a LOOP issue.

## Test plan
- Reset, then program 0:{MARK, agen0 sel=0001}, 1:{LOOP}, 2:{HALT, dsp_op=0x5A}, N_SERIES=25, start at t.
  - Response: word 0 at t+2; `series_rst`=1 at t+2.
  - Words 0/1 alternate 25 times with `series_inc`=1 on the first 24 LOOP issues.
  - `series_rst`=1 on the 25th LOOP issue; `dsp_op`=0x5A on the HALT cycle; `done` the next cycle.
  - Total busy cycles = 1+50+1.
- Straight-line program of 4 words, HALT at addr 3.
  - Response: words issued at t+2..t+5, `done` at t+6, `loop_idx` stays 0.
- Memory filled with no HALT.
  - Response: 64 words issued, then `overrun`=1 and `done`.
  - `overrun` holds through IDLE and clears on the next `start`.
- `start` and `prog_we` (addr 0, new data) pulsed mid-run.
  - Response: both ignored; readback on the next run shows the original word 0.
- `rst` asserted in the 10th RUN cycle.
  - Response: all outputs 0 next cycle, no `done`; the next `start` restarts from word 0 with `loop_cnt`=0.
- Word 5 = {MARK, LOOP, HALT}.
  - Response: HALT wins; no `series_inc`; `done` the next cycle.
